// File: rtl/fft_pkg.sv
// fft_pkg: shared sample widths, complex pack/unpack helpers and saturation bounds
package fft_pkg;
  localparam int HALF_W = 4;
  localparam int DATA_W = 2*HALF_W;
  localparam int SAT_MAX = 2**(HALF_W-1)-1;
  localparam int SAT_MIN = -(2**(HALF_W-1));
  function automatic logic signed [HALF_W-1:0] cplx_re(input logic [DATA_W-1:0] d);
    return d[DATA_W-1:HALF_W];
  endfunction
  function automatic logic signed [HALF_W-1:0] cplx_im(input logic [DATA_W-1:0] d);
    return d[HALF_W-1:0];
  endfunction
  function automatic logic [DATA_W-1:0] cplx_pack(input logic [HALF_W-1:0] re, input logic [HALF_W-1:0] im);
    return {re, im};
  endfunction
endpackage

// File: rtl/fft4_input_butterfly_if.sv
// fft4_input_butterfly_if: serial sample input (in_valid/in_ready/in_sof/in_data), parallel frame output (out_valid/out_ready/e0/e1/o0/o1), err_sof; slave = block, master = driver
interface fft4_input_butterfly_if;
  import fft_pkg::*;
  logic in_valid, in_ready, in_sof, out_valid, out_ready, err_sof;
  logic [DATA_W-1:0] in_data, e0, e1, o0, o1;
  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, e0, e1, o0, o1, err_sof
  );
  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, e0, e1, o0, o1, err_sof
  );
endinterface

// File: rtl/fft4_input_butterfly_cplx_addsub.sv
// cplx_addsub: packed complex sum=a+b, dif=a-b per component; ports a,b,sum,dif; saturates when FFT_SAT_EN is defined, wraps otherwise
module cplx_addsub
  import fft_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] dif
);
  function automatic logic signed [HALF_W:0] ext(input logic signed [HALF_W-1:0] x);
    return {x[HALF_W-1], x};
  endfunction
  function automatic logic [HALF_W-1:0] fit(input logic signed [HALF_W:0] v);
`ifdef FFT_SAT_EN
    return v > SAT_MAX ? HALF_W'(SAT_MAX) : v < SAT_MIN ? HALF_W'(SAT_MIN) : v[HALF_W-1:0];
`else
    return v[HALF_W-1:0];
`endif
  endfunction
  assign sum = cplx_pack(fit(ext(cplx_re(a)) + ext(cplx_re(b))), fit(ext(cplx_im(a)) + ext(cplx_im(b))));
  assign dif = cplx_pack(fit(ext(cplx_re(a)) - ext(cplx_re(b))), fit(ext(cplx_im(a)) - ext(cplx_im(b))));
endmodule

// File: rtl/fft4_input_butterfly.sv
// fft4_input_butterfly: radix-2 input stage of a 4-point FFT; ports clk, rst_n (async low), bus (slave modport); FFT_SAT_EN selects saturating arithmetic
module fft4_input_butterfly
  import fft_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fft4_input_butterfly_if.slave bus
);
  logic [1:0] cnt;
  logic [DATA_W-1:0] x0, x1, s02, d02, s13, d13;
  logic acc;
  assign bus.in_ready = !(cnt[1] && bus.out_valid && !bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;
  cplx_addsub u_02 (.a(x0), .b(bus.in_data), .sum(s02), .dif(d02));
  cplx_addsub u_13 (.a(x1), .b(bus.in_data), .sum(s13), .dif(d13));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 2'd0;
      x0 <= '0;
      x1 <= '0;
      bus.e0 <= '0;
      bus.e1 <= '0;
      bus.o0 <= '0;
      bus.o1 <= '0;
      bus.out_valid <= 1'b0;
      bus.err_sof <= 1'b0;
    end else begin
      bus.err_sof <= acc && bus.in_sof && cnt != 2'd0;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (acc && bus.in_sof) begin
        x0 <= bus.in_data;
        cnt <= 2'd1;
      end else if (acc) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd0) x0 <= bus.in_data;
        if (cnt == 2'd1) x1 <= bus.in_data;
        if (cnt == 2'd2) begin
          bus.e0 <= s02;
          bus.e1 <= d02;
        end
        if (cnt == 2'd3) begin
          bus.o0 <= s13;
          bus.o1 <= d13;
          bus.out_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_fft4_input_butterfly.sv
// tb_fft4_input_butterfly: directed frames with a queued scoreboard checked by an output monitor
module tb_fft4_input_butterfly;
  import fft_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fft4_input_butterfly_if bus();
  fft4_input_butterfly dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [4*DATA_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int stalls = 0;
`ifdef FFT_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'h70000000;
  localparam logic [31:0] C_EXP = 32'hF07E0000;
`else
  localparam logic [31:0] OVF_EXP = 32'hE0000000;
  localparam logic [31:0] C_EXP = 32'hF0FE0000;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_extra: got %h want none", {bus.e0, bus.e1, bus.o0, bus.o1});
      end else chk("frame", {bus.e0, bus.e1, bus.o0, bus.o1}, exp_q.pop_front());
    end
  task automatic send(input logic [7:0] d, input logic sof);
    logic r;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_sof = sof;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      stalls++;
      if (t == 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no accept want accept of %h", d);
        break;
      end
    end
    bus.in_sof = 1'b0;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d, input logic [31:0] exp);
    exp_q.push_back(exp);
    send(a, 1'b1);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_frame", {bus.e0, bus.e1, bus.o0, bus.o1}, 0);
    chk("rst_err_sof", bus.err_sof, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(8'h10, 8'h20, 8'h30, 8'h10, 32'h40E03010);
    chk("basic_latency_valid", bus.out_valid, 1);
    chk("basic_direct", {bus.e0, bus.e1, bus.o0, bus.o1}, 32'h40E03010);
    idle();
    chk("basic_consumed", bus.out_valid, 0);
    frame(8'h70, 8'h00, 8'h70, 8'h00, OVF_EXP);
    idle();
    idle();
    bus.out_ready = 1'b0;
    frame(8'h11, 8'h22, 8'h33, 8'h44, 32'h44EE66EE);
    idle();
    chk("bp_held_valid", bus.out_valid, 1);
    exp_q.push_back(32'h66407430);
    send(8'h53, 1'b1);
    send(8'h52, 1'b0);
    chk("bp_x01_accepted_hold", {bus.e0, bus.e1, bus.o0, bus.o1}, 32'h44EE66EE);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h13;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_stable", {bus.e0, bus.e1, bus.o0, bus.o1}, 32'h44EE66EE);
    chk("bp_still_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    send(8'h13, 1'b0);
    chk("bp_no_torn_frame", bus.out_valid, 0);
    send(8'h22, 1'b0);
    idle();
    idle();
    stalls = 0;
    frame(8'h01, 8'h02, 8'h03, 8'h04, 32'h040E060E);
    frame(8'hF0, 8'h10, 8'hF0, 8'h10, 32'hE0002000);
    frame(8'h7F, 8'h00, 8'h81, 8'h00, C_EXP);
    idle();
    chk("b2b_no_stall", stalls, 0);
    idle();
    send(8'h10, 1'b1);
    exp_q.push_back(32'h60E04020);
    send(8'h20, 1'b1);
    chk("resync_err_pulse", bus.err_sof, 1);
    send(8'h30, 1'b0);
    chk("resync_err_once", bus.err_sof, 0);
    send(8'h40, 1'b0);
    send(8'h10, 1'b0);
    idle();
    idle();
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("mid_e_written", {bus.e0, bus.e1}, 32'h000044EE);
    chk("mid_no_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_frame", {bus.e0, bus.e1, bus.o0, bus.o1}, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h321033F1);
    send(8'h21, 1'b0);
    send(8'h12, 1'b0);
    send(8'h11, 1'b0);
    send(8'h21, 1'b0);
    repeat (4) idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
